memint_ctrl: RTL
================

# memint_ctrl

Parametrised data-memory interface controller placed between the control unit and the external data-memory bus of the CPU top level. Converts a single-cycle request from the control unit into a sequenced memory transaction on the `cmd_memory` / `addr_memory` / `data_memory` bus, with configurable widths and optional wait states. Owns the tri-state data bus and guarantees it is only driven during write access cycles. Returns read data and a one-cycle acknowledge to the control unit.

## Interface
- `DW`, 8: data width, both CU side and memory side.
- `AW`, 8: address width.
- `CW`, 8: command bus width.
- `WAIT`, 1: wait-state cycles added after SETUP; 0 is legal.
- `CMD_IDLE`, 0: command code driven when no access is in progress.
- `CMD_READ`, 1: read command code.
- `CMD_WRITE`, 2: write command code.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `cu_req`  in  1: transaction request, sampled only in IDLE.
- `cu_we`  in  1: 1 = write, 0 = read; sampled with `cu_req`.
- `cu_addr`  in  AW: access address; sampled with `cu_req`.
- `cu_wdata`  in  DW: write data; sampled with `cu_req`.
- `cu_rdata`  out  DW: registered read data; holds until the next read completes.
- `cu_ack`  out  1: one-cycle completion pulse.
- `cu_busy`  out  1: high whenever state is not IDLE.
- `cmd_memory`  out  CW: memory command.
- `addr_memory`  out  AW: memory address, registered.
- `data_memory`  inout  DW: bidirectional data bus; high-Z unless a write is in SETUP or WAIT.

## Operation
- FSM states: IDLE, SETUP, WAIT, DONE.
- IDLE:
  - `cu_req`=1 latches `cu_we`, `cu_addr` and `cu_wdata`, then moves to SETUP.
  - `cu_req`=0 stays in IDLE.
- SETUP:
  - `cmd_memory` = CMD_READ or CMD_WRITE; `addr_memory` = latched address.
  - On a write, `data_memory` is driven with the latched data.
  - Next state: WAIT when WAIT>0, otherwise DONE.
- WAIT:
  - Command, address and write data are held.
  - The counter loads WAIT−1 on entry and decrements each cycle; the FSM leaves WAIT when the counter reaches 0.
  - Counter width is `$clog2(WAIT+1)`, minimum 1.
- Read capture: `data_memory` is sampled into `cu_rdata` on the edge that leaves the last access cycle (SETUP or WAIT).
- DONE:
  - `cu_ack`=1; `cmd_memory` = CMD_IDLE; bus released to high-Z.
  - `addr_memory` keeps its last value.
  - Always moves to IDLE on the next edge.
- Requests outside IDLE are ignored, not queued. `cu_busy` tells the CU when it may issue a request.
- Writes never modify `cu_rdata`.
- Reset value of every output:
  - `cmd_memory` = CMD_IDLE, `addr_memory` = 0, `cu_rdata` = 0.
  - `cu_ack` = 0, `cu_busy` = 0, `data_memory` = high-Z.
  - FSM = IDLE, counter = 0.
- Reset during a transaction: takes effect immediately. The transaction is aborted, the bus goes high-Z in the same cycle, and no `cu_ack` is produced.

## Timing
- Let E0 be the edge that samples `cu_req`.
  - SETUP occupies the cycle after E0.
  - WAIT occupies the next WAIT cycles.
  - DONE (`cu_ack` high) occupies the cycle after edge E0+1+WAIT.
- Request-to-ack latency is WAIT+2 cycles.
- The earliest next request is sampled at edge E0+WAIT+3. A request held high through DONE is accepted at that edge.
- The external memory must present read data within the last access cycle, combinationally from `cmd_memory` and `addr_memory`.
- Bus turnaround: the controller stops driving at the first edge of DONE, leaving at least one cycle of high-Z between transactions.

## Configuration
- `MEMINT_WAIT_EN`:
  - Defined: the WAIT parameter is honoured as described above.
  - Undefined: the WAIT state and counter are not compiled in; SETUP always goes to DONE and latency is fixed at 2 cycles regardless of WAIT.

## Test plan
- Reset: assert `rst` mid-cycle with `cu_req`=1 → all outputs at their reset values immediately; `data_memory` reads as high-Z; no ack follows release.
- Write, WAIT=2, macro defined: `cu_req`=1, `cu_we`=1, addr 0x3C, data 0xA5 → `cmd_memory`=2, `addr_memory`=0x3C and `data_memory`=0xA5 for 3 cycles; `cu_ack` high for exactly 1 cycle, 4 cycles after E0; bus high-Z in DONE.
- Read, WAIT=0: memory returns 0x5A at addr 0x10 → `cu_ack` 2 cycles after E0; `cu_rdata`=0x5A and stays 0x5A through a following write.
- Busy rejection: pulse `cu_req` during WAIT with a different address → ignored; `addr_memory` unchanged; exactly one ack.
- Back-to-back: `cu_req` held high → accepts occur every WAIT+3 cycles; IDLE lasts one cycle between transactions.
- Macro undefined, WAIT=3: a read completes with ack 2 cycles after E0.

Source files
------------

// File: rtl/memint_ctrl_if.sv
// memint_ctrl_if: control-unit side request/acknowledge bundle of the data-memory
// interface controller. The CU drives the request fields (master); the controller
// returns read data, a completion pulse and its busy flag (slave).
interface memint_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          cu_req;
  logic          cu_we;
  logic [AW-1:0] cu_addr;
  logic [DW-1:0] cu_wdata;
  logic [DW-1:0] cu_rdata;
  logic          cu_ack;
  logic          cu_busy;

  modport master (
    output cu_req, cu_we, cu_addr, cu_wdata,
    input  cu_rdata, cu_ack, cu_busy
  );

  modport slave (
    input  cu_req, cu_we, cu_addr, cu_wdata,
    output cu_rdata, cu_ack, cu_busy
  );
endinterface

// File: rtl/memint_ctrl.sv
// memint_ctrl: turns a single-cycle CU request into a sequenced access on the
// external data-memory bus (IDLE -> SETUP -> [WAIT x N] -> DONE -> IDLE).
// The controller owns the tri-state data bus and drives it only while a write
// is in SETUP or WAIT.
// Build option: define MEMINT_WAIT_EN to honour the WAIT parameter; without it
// the WAIT state and its counter are left out and every access takes 2 cycles.
module memint_ctrl #(
  parameter int              DW        = 8,
  parameter int              AW        = 8,
  parameter int              CW        = 8,
  parameter int              WAIT      = 1,
  parameter logic [CW-1:0]   CMD_IDLE  = CW'(0),
  parameter logic [CW-1:0]   CMD_READ  = CW'(1),
  parameter logic [CW-1:0]   CMD_WRITE = CW'(2)
) (
  input  logic             clk,
  input  logic             rst,
  memint_ctrl_if.slave     cu,
  output logic [CW-1:0]    cmd_memory,
  output logic [AW-1:0]    addr_memory,
  inout  wire  [DW-1:0]    data_memory
);

  // A negative wait count has no meaning in any build.
  if (WAIT < 0) begin : g_wait_chk
    $error("memint_ctrl: WAIT must be >= 0");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          last_access;
  logic          drive_en;

`ifdef MEMINT_WAIT_EN
  localparam int             CNT_W    = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wait-state counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Counter loads on the way out of SETUP and counts down to zero inside WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_SETUP) begin
      cnt_d = CNT_LOAD;
    end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // The last access cycle is SETUP when there are no wait states, otherwise
  // the WAIT cycle whose counter has reached zero.
  always_comb begin
    last_access = ((state_q == ST_SETUP) && (WAIT == 0)) ||
                  ((state_q == ST_WAIT) && (cnt_q == '0));
  end
`else
  // Without wait states SETUP is always the one and only access cycle.
  always_comb begin
    last_access = (state_q == ST_SETUP);
  end
`endif

  // State register; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; requests are only looked at in IDLE, never queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cu.cu_req) state_d = ST_SETUP;
      end
      ST_SETUP: begin
`ifdef MEMINT_WAIT_EN
        state_d = (WAIT > 0) ? ST_WAIT : ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
      ST_WAIT: begin
`ifdef MEMINT_WAIT_EN
        if (cnt_q == '0) state_d = ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: command and bus drive only during access cycles, ack in DONE.
  always_comb begin
    cmd_memory  = CMD_IDLE;
    drive_en    = 1'b0;
    cu.cu_ack   = (state_q == ST_DONE);
    cu.cu_busy  = (state_q != ST_IDLE);
    if ((state_q == ST_SETUP) || (state_q == ST_WAIT)) begin
      cmd_memory = we_q ? CMD_WRITE : CMD_READ;
      drive_en   = we_q;
    end
  end

  // Request latch and read-data capture.
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if ((state_q == ST_IDLE) && cu.cu_req) begin
      we_d    = cu.cu_we;
      addr_d  = cu.cu_addr;
      wdata_d = cu.cu_wdata;
    end
    // The memory answers combinationally, so the bus is valid by the end of
    // the last access cycle; writes never touch the read register.
    if (last_access && !we_q) begin
      rdata_d = data_memory;
    end
  end

  // Transaction and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign addr_memory = addr_q;
  assign cu.cu_rdata = rdata_q;
  assign data_memory = drive_en ? wdata_q : {DW{1'bz}};

endmodule
